// File: rtl/grid_mover_pkg.sv
// Shared direction / FSM encodings for grid_mover.
// Direction codes are also used by the sprite renderer for facing.
package grid_mover_pkg;

    typedef enum logic [1:0] {
        DIR_UP = 2'd0,
        DIR_DN = 2'd1,
        DIR_LT = 2'd2,
        DIR_RT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // width of a counter that must reach max(a, b) - 1
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/grid_mover_debounce.sv
// Two-flop synchroniser followed by a stable-sample counter.
// Output level follows the input only after STABLE_CYC equal samples.
module debounce_filter
    import grid_mover_pkg::*;
#(
    parameter int STABLE_CYC = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Raw,
    output logic o_Level
);

    localparam int CW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYC - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    // bring the asynchronous button into the clock domain
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= i_Raw;
            sync <= meta;
        end
    end

    // flip the level once the synced input disagrees for STABLE_CYC samples
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cnt     <= '0;
            o_Level <= 1'b0;
        end else if (sync == o_Level) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt     <= '0;
            o_Level <= sync;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/grid_mover.sv
// Button-driven grid position controller with debounce,
// hold-to-repeat, and clamp-or-wrap edge handling.
module grid_mover
    import grid_mover_pkg::*;
#(
    parameter int POS_W         = 10,
    parameter int STEP          = 32,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 608,
    parameter int Y_MIN         = 0,
    parameter int Y_MAX         = 448,
    parameter int X_INIT        = 0,
    parameter int Y_INIT        = 448,
    parameter int WRAP          = 0,
    parameter int DEBOUNCE_CYC  = 250000,
    parameter int REP_DELAY_CYC = 12500000,
    parameter int REP_RATE_CYC  = 2500000
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Up,
    input  logic             i_Dn,
    input  logic             i_Lt,
    input  logic             i_Rt,
    input  logic             i_Enable,
    output logic [POS_W-1:0] o_X,
    output logic [POS_W-1:0] o_Y,
    output logic             o_Step,
    output logic [1:0]       o_Dir,
    output logic             o_Bump
);

    localparam int PW    = POS_W + 1;
    localparam int CNT_W = cnt_width(REP_DELAY_CYC, REP_RATE_CYC);

    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REP_DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REP_RATE_CYC - 1);

    localparam logic [PW-1:0]    STEP_W = PW'(STEP);
    localparam logic [POS_W-1:0] X_LO   = POS_W'(X_MIN);
    localparam logic [POS_W-1:0] X_HI   = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] Y_LO   = POS_W'(Y_MIN);
    localparam logic [POS_W-1:0] Y_HI   = POS_W'(Y_MAX);

    logic [3:0]       lvl;
    logic [3:0]       lvl_q;
    logic [3:0]       rise;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    dir_t             dir_q;
    dir_t             dir_n;
    dir_t             pick;
    dir_t             req_dir;
    logic             held;
    logic             req;

    logic             is_y;
    logic             fwd;
    logic             under;
    logic             over;
    logic [PW-1:0]    cur;
    logic [PW-1:0]    tgt;
    logic [POS_W-1:0] lo;
    logic [POS_W-1:0] hi;
    logic [POS_W-1:0] nxt;

    debounce_filter #(.STABLE_CYC(DEBOUNCE_CYC)) u_db_up (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Raw(i_Up), .o_Level(lvl[0])
    );
    debounce_filter #(.STABLE_CYC(DEBOUNCE_CYC)) u_db_dn (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Raw(i_Dn), .o_Level(lvl[1])
    );
    debounce_filter #(.STABLE_CYC(DEBOUNCE_CYC)) u_db_lt (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Raw(i_Lt), .o_Level(lvl[2])
    );
    debounce_filter #(.STABLE_CYC(DEBOUNCE_CYC)) u_db_rt (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Raw(i_Rt), .o_Level(lvl[3])
    );

    assign rise = lvl & ~lvl_q;
    assign held = lvl[dir_q];

    // fresh press direction, Up beats Dn beats Lt beats Rt
    always_comb begin
        pick = DIR_RT;
        priority case (1'b1)
            rise[0]: pick = DIR_UP;
            rise[1]: pick = DIR_DN;
            rise[2]: pick = DIR_LT;
            default: pick = DIR_RT;
        endcase
    end

    // FSM state, repeat counter, latched direction and edge history
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            dir_q <= DIR_UP;
            lvl_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            dir_q <= dir_n;
            lvl_q <= lvl;
        end
    end

    // next-state: release always wins over timer expiry
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dir_n   = dir_q;
        if (!i_Enable) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (|rise) begin
                        state_n = ST_DELAY;
                        cnt_n   = '0;
                        dir_n   = pick;
                    end
                end
                ST_DELAY: begin
                    if (!held) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else if (cnt == DLY_LAST) begin
                        state_n = ST_REPEAT;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!held) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else if (cnt == RATE_LAST) begin
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // step requests from press, first repeat and periodic repeat
    always_comb begin
        req     = 1'b0;
        req_dir = dir_q;
        if (i_Enable) begin
            unique case (state)
                ST_IDLE: begin
                    if (|rise) begin
                        req     = 1'b1;
                        req_dir = pick;
                    end
                end
                ST_DELAY:  req = held && (cnt == DLY_LAST);
                ST_REPEAT: req = held && (cnt == RATE_LAST);
                default:   req = 1'b0;
            endcase
        end
    end

    // target on the requested axis, one bit wider than the position
    always_comb begin
        is_y  = (req_dir == DIR_UP) || (req_dir == DIR_DN);
        fwd   = (req_dir == DIR_DN) || (req_dir == DIR_RT);
        cur   = is_y ? {1'b0, o_Y} : {1'b0, o_X};
        lo    = is_y ? Y_LO : X_LO;
        hi    = is_y ? Y_HI : X_HI;
        tgt   = fwd ? cur + STEP_W : cur - STEP_W;
        under = !fwd && (cur < ({1'b0, lo} + STEP_W));
        over  = fwd && (tgt > {1'b0, hi});
        nxt   = tgt[POS_W-1:0];
        if (under) begin
            nxt = hi;
        end else if (over) begin
            nxt = lo;
        end
    end

    // position and event pulses, updated on the edge after a request
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_X    <= POS_W'(X_INIT);
            o_Y    <= POS_W'(Y_INIT);
            o_Step <= 1'b0;
            o_Bump <= 1'b0;
            o_Dir  <= DIR_UP;
        end else begin
            o_Step <= 1'b0;
            o_Bump <= 1'b0;
            if (req) begin
                o_Dir <= req_dir;
                if ((under || over) && (WRAP == 0)) begin
                    o_Bump <= 1'b1;
                end else begin
                    o_Step <= 1'b1;
                    if (is_y) begin
                        o_Y <= nxt;
                    end else begin
                        o_X <= nxt;
                    end
                end
            end
        end
    end

endmodule
